ex_result_skid_buffer: RTL and testbench

//   EX->MEM boundary register for the 32-bit ALU. Captures the ALU result, its four flags and the

---
 rtl/ex_result_skid_buffer.sv | 106 ++++++++++
 tb/tb_ex_result_skid_buffer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ex_result_skid_buffer.sv
// ex_result_skid_buffer: two-entry EX->MEM skid buffer carrying ALU result, flags and rd tag,
// with a forwarding tap on the head entry.
module ex_result_skid_buffer #(
    parameter int DATA_W = 32,
    parameter int FLAG_W = 4,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [FLAG_W-1:0] in_flags,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_wen,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [FLAG_W-1:0] out_flags,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_wen,
    output logic              fwd_valid,
    output logic [1:0]        occupancy
);
    localparam int PW = DATA_W + FLAG_W + RD_W + 1;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t          state_q;
    logic [PW-1:0]   head_q, skid_q;
    logic            in_ready_q, out_valid_q, fwd_valid_q;
    logic [1:0]      occ_q;
    logic            in_xfer, out_xfer;
    logic [PW-1:0]   in_payload_d;

    // wen is sanitised on entry so x0 is never written back or forwarded
    assign in_payload_d = {in_result, in_flags, in_rd, in_wen & (in_rd != '0)};
    assign in_xfer      = in_valid & in_ready_q;
    assign out_xfer     = out_valid_q & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            fwd_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else if (flush) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            fwd_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            case (state_q)
                EMPTY: if (in_xfer) begin
                    state_q     <= ONE;
                    head_q      <= in_payload_d;
                    out_valid_q <= 1'b1;
                    fwd_valid_q <= in_payload_d[0];
                    occ_q       <= 2'd1;
                end
                ONE: if (in_xfer && out_xfer) begin
                    head_q      <= in_payload_d;
                    fwd_valid_q <= in_payload_d[0];
                end else if (in_xfer) begin
                    state_q     <= FULL;
                    skid_q      <= in_payload_d;
                    in_ready_q  <= 1'b0;
                    occ_q       <= 2'd2;
                end else if (out_xfer) begin
                    state_q     <= EMPTY;
                    out_valid_q <= 1'b0;
                    fwd_valid_q <= 1'b0;
                    occ_q       <= 2'd0;
                end
                FULL: if (out_xfer) begin
                    state_q     <= ONE;
                    head_q      <= skid_q;
                    in_ready_q  <= 1'b1;
                    fwd_valid_q <= skid_q[0];
                    occ_q       <= 2'd1;
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    fwd_valid_q <= 1'b0;
                    occ_q       <= 2'd0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign fwd_valid  = fwd_valid_q;
    assign occupancy  = occ_q;
    assign out_result = head_q[PW-1 -: DATA_W];
    assign out_flags  = head_q[RD_W+1 +: FLAG_W];
    assign out_rd     = head_q[1 +: RD_W];
    assign out_wen    = head_q[0];
endmodule

// File: tb/tb_ex_result_skid_buffer.sv
// tb_ex_result_skid_buffer: directed bench for the EX->MEM skid buffer.
module tb_ex_result_skid_buffer;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, in_wen;
    logic [31:0] in_result, out_result;
    logic [3:0]  in_flags, out_flags;
    logic [4:0]  in_rd, out_rd;
    logic        out_valid, out_ready, out_wen, fwd_valid;
    logic [1:0]  occupancy;
    int          checks = 0;
    int          failures = 0;

    ex_result_skid_buffer dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .in_rd(in_rd), .in_wen(in_wen),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags), .out_rd(out_rd), .out_wen(out_wen),
        .fwd_valid(fwd_valid), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic [3:0] f,
                         input logic [4:0] rd, input logic w);
        in_valid  = v;
        in_result = r;
        in_flags  = f;
        in_rd     = rd;
        in_wen    = w;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 5'd0, 1'b0);
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_wen", 32'(out_wen), 32'd0);
        chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        rst_n = 1'b1;
        #2;

        // full-rate stream
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), 4'h0, 5'd1, 1'b1);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            tick();
            chk("stream_out_valid", 32'(out_valid), 32'd1);
            chk("stream_out_result", out_result, 32'(i));
            chk("stream_occ", 32'(occupancy), 32'd1);
        end
        drive(1'b0, 32'h0, 4'h0, 5'd0, 1'b0);
        tick();
        chk("stream_drain", 32'(out_valid), 32'd0);

        // flags pass through untouched
        out_ready = 1'b0;
        drive(1'b1, 32'h8000_0000, 4'b0110, 5'd3, 1'b1);
        tick();
        chk("flags_value", 32'(out_flags), 32'h6);
        chk("flags_result", out_result, 32'h8000_0000);
        drive(1'b0, 32'h0, 4'h0, 5'd0, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("flags_drain", 32'(occupancy), 32'd0);

        // x0 write-enable filter
        drive(1'b1, 32'hDEAD_BEEF, 4'h0, 5'd0, 1'b1);
        tick();
        chk("x0_out_wen", 32'(out_wen), 32'd0);
        chk("x0_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("x0_out_result", out_result, 32'hDEAD_BEEF);
        drive(1'b1, 32'h55, 4'h0, 5'd5, 1'b1);
        tick();
        chk("x5_out_wen", 32'(out_wen), 32'd1);
        chk("x5_fwd_valid", 32'(fwd_valid), 32'd1);
        chk("x5_out_rd", 32'(out_rd), 32'd5);
        drive(1'b0, 32'h0, 4'h0, 5'd0, 1'b0);
        tick();
        chk("x0_drain", 32'(out_valid), 32'd0);

        // backpressure fills both entries, then drains in order
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 4'h0, 5'd1, 1'b1);
        tick();
        chk("bp_occ_a", 32'(occupancy), 32'd1);
        chk("bp_ready_a", 32'(in_ready), 32'd1);
        drive(1'b1, 32'hB, 4'h0, 5'd1, 1'b1);
        tick();
        chk("bp_occ_b", 32'(occupancy), 32'd2);
        chk("bp_ready_b", 32'(in_ready), 32'd0);
        chk("bp_head_a", out_result, 32'hA);
        drive(1'b1, 32'hC, 4'h0, 5'd1, 1'b1);
        tick();
        chk("bp_occ_hold", 32'(occupancy), 32'd2);
        chk("bp_head_hold", out_result, 32'hA);
        out_ready = 1'b1;
        tick();
        chk("bp_head_b", out_result, 32'hB);
        chk("bp_occ_after_b", 32'(occupancy), 32'd1);
        tick();
        chk("bp_head_c", out_result, 32'hC);
        chk("bp_valid_c", 32'(out_valid), 32'd1);
        drive(1'b0, 32'h0, 4'h0, 5'd0, 1'b0);
        tick();
        chk("bp_drain", 32'(out_valid), 32'd0);

        // flush voids both held entries and the concurrent input
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 4'h0, 5'd2, 1'b1);
        tick();
        drive(1'b1, 32'h22, 4'h0, 5'd2, 1'b1);
        tick();
        chk("fl_full", 32'(occupancy), 32'd2);
        flush = 1'b1; out_ready = 1'b1;
        drive(1'b1, 32'h33, 4'h0, 5'd2, 1'b1);
        tick();
        chk("fl_occ", 32'(occupancy), 32'd0);
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        flush = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 5'd0, 1'b0);
        tick();
        chk("fl_no_ghost", 32'(out_valid), 32'd0);
        drive(1'b1, 32'h44, 4'h0, 5'd2, 1'b1);
        tick();
        chk("fl_next_entry", out_result, 32'h44);
        chk("fl_next_occ", 32'(occupancy), 32'd1);
        drive(1'b0, 32'h0, 4'h0, 5'd0, 1'b0);
        tick();

        // asynchronous reset in the middle of a FULL buffer
        out_ready = 1'b0;
        drive(1'b1, 32'h77, 4'h0, 5'd4, 1'b1);
        tick();
        drive(1'b1, 32'h88, 4'h0, 5'd4, 1'b1);
        tick();
        chk("ar_full", 32'(occupancy), 32'd2);
        drive(1'b0, 32'h0, 4'h0, 5'd0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_occ", 32'(occupancy), 32'd0);
        chk("ar_in_ready", 32'(in_ready), 32'd1);
        chk("ar_out_result", out_result, 32'd0);
        #3 rst_n = 1'b1;
        drive(1'b1, 32'h99, 4'h0, 5'd4, 1'b1);
        tick();
        chk("ar_first_accept", out_result, 32'h99);
        chk("ar_first_occ", 32'(occupancy), 32'd1);
        drive(1'b0, 32'h0, 4'h0, 5'd0, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("ar_skid_gone", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
